reg2axil: RTL and testbench

REG2AXIL -- requirements
Module: reg2axil

---
 rtl/reg2axil_if.sv | 56 +++++
 rtl/reg2axil.sv | 150 +++++++++++++++
 tb/tb_reg2axil.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg2axil_if.sv
// -----------------------------------------------------------------------------
// reg2axil_if -- AXI4-Lite bus bundle used by the reg2axil bridge.
//
// Parameters
//   ADDR_WIDTH : address width of AW/AR
//   DATA_WIDTH : data width of W/R (32 or 64); strobe width is DATA_WIDTH/8
//
// Modports
//   master : the bridge side (drives AW/W/AR payload + valid, B/R ready)
//   slave  : the memory/peripheral side
// -----------------------------------------------------------------------------
interface reg2axil_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // write address channel
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  // write data channel
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  // write response channel
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  // read address channel
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  // read data channel
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/reg2axil.sv
// -----------------------------------------------------------------------------
// reg2axil -- single-outstanding register-command to AXI4-Lite master bridge.
//
// A command (cmd_*) is accepted in IDLE, turned into one AXI4-Lite write
// (AW + W, then B) or read (AR, then R), and the outcome is presented on the
// response port (rsp_*) until consumed. Only one transaction is in flight.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   cmd_valid / cmd_ready : command handshake; cmd_ready is high only in IDLE
//   cmd_we                : 1 = write, 0 = read
//   cmd_addr, cmd_wdata   : target address, write data
//   rsp_valid / rsp_ready : response handshake
//   rsp_rdata             : read data (0 for writes)
//   rsp_okay              : 1 when the AXI response was OKAY
//   m_axil                : AXI4-Lite master bus
// -----------------------------------------------------------------------------
module reg2axil #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_okay,
  reg2axil_if.master            m_axil
);

  typedef enum logic [2:0] {IDLE, WR, WR_B, RD, RD_R, RSP} state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  state_t                state, state_nxt;
  logic                  aw_done, w_done;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic cmd_hs, aw_hs, w_hs;
  assign cmd_hs = cmd_valid && cmd_ready;
  assign aw_hs  = m_axil.awvalid && m_axil.awready;
  assign w_hs   = m_axil.wvalid  && m_axil.wready;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs. Every output here is a decode of
  // registered state/flags only, so no input reaches a *valid combinationally.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_nxt      = state;
    cmd_ready      = 1'b0;
    rsp_valid      = 1'b0;
    m_axil.awvalid = 1'b0;
    m_axil.wvalid  = 1'b0;
    m_axil.bready  = 1'b0;
    m_axil.arvalid = 1'b0;
    m_axil.rready  = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = cmd_we ? WR : RD;
      end
      WR: begin
        // AW and W complete independently; each valid drops once its own
        // handshake is recorded and never comes back for this write.
        m_axil.awvalid = !aw_done;
        m_axil.wvalid  = !w_done;
        if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WR_B;
      end
      WR_B: begin
        m_axil.bready = 1'b1;
        if (m_axil.bvalid) state_nxt = RSP;
      end
      RD: begin
        m_axil.arvalid = 1'b1;
        if (m_axil.arready) state_nxt = RD_R;
      end
      RD_R: begin
        m_axil.rready = 1'b1;
        if (m_axil.rvalid) state_nxt = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Per-channel completion flags for the write address/data phases; cleared
  // when the next command is taken so each write starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (cmd_hs) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

  // Command holding registers. Direction is captured by the WR/RD choice.
  // NOTE: pure datapath holding registers carry no reset; they are always
  // loaded before anything downstream looks at them.
  always_ff @(posedge clk) begin
    if (cmd_hs) begin
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
    end
  end

  // Response capture; reset so the response port reads zero until the first
  // transaction completes. Error responses complete normally with okay = 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_okay  <= 1'b0;
    end else if (state == WR_B && m_axil.bvalid) begin
      rsp_rdata <= '0;
      rsp_okay  <= (m_axil.bresp == RESP_OKAY);
    end else if (state == RD_R && m_axil.rvalid) begin
      rsp_rdata <= m_axil.rdata;
      rsp_okay  <= (m_axil.rresp == RESP_OKAY);
    end
  end

  assign m_axil.awaddr = addr_q;
  assign m_axil.araddr = addr_q;
  assign m_axil.awprot = 3'b000;
  assign m_axil.arprot = 3'b000;
  assign m_axil.wdata  = wdata_q;
  assign m_axil.wstrb  = '1;

endmodule

// File: tb/tb_reg2axil.sv
// -----------------------------------------------------------------------------
// tb_reg2axil -- self-checking bench for reg2axil.
// A behavioural AXI4-Lite slave with per-channel delays sits on the bus; a
// simple address->data map predicts every response. The top quarter of each
// 256-byte window answers with errors (SLVERR, or DECERR when bit 5 is set).
// -----------------------------------------------------------------------------
module tb_reg2axil;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_we = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_okay;

  always #5 clk = ~clk;

  reg2axil_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axil ();

  reg2axil #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_okay(rsp_okay),
    .m_axil(axil)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- system definition shared by slave and model -------------
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [1:0] resp_of(input logic [AW-1:0] a);
    if (a[7:6] == 2'b11) return a[5] ? 2'b11 : 2'b10;
    return 2'b00;
  endfunction

  // ---------------- behavioural slave + protocol monitor --------------------
  logic [DW-1:0] slv_mem [logic [AW-1:0]];
  int max_dly = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  bit got_aw, got_w, got_ar, aw_seen, w_seen;
  logic [AW-1:0] aw_addr_c, ar_addr_c, awaddr_q, araddr_q;
  logic [DW-1:0] w_data_c, wdata_q;
  bit awv_q, awr_q, wv_q, wr_q, bv_q, br_q, arv_q, arr_q, rv_q, rr_q;

  function automatic int next_dly();
    return int'($urandom_range(0, max_dly));
  endfunction

  function automatic logic [DW-1:0] slv_rd(input logic [AW-1:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : init_val(a);
  endfunction

  // Slave and monitor act on the falling edge; the *_q copies hold what was on
  // the bus at the rising edge just passed, so *_hs means that edge handshook.
  always @(negedge clk) begin
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    if (!rst_n) begin
      axil.awready = 1'b0; axil.wready = 1'b0; axil.arready = 1'b0;
      axil.bvalid  = 1'b0; axil.bresp  = 2'b00;
      axil.rvalid  = 1'b0; axil.rresp  = 2'b00; axil.rdata = '0;
      got_aw = 0; got_w = 0; got_ar = 0; aw_seen = 0; w_seen = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      awv_q = 0; awr_q = 0; wv_q = 0; wr_q = 0; bv_q = 0; br_q = 0;
      arv_q = 0; arr_q = 0; rv_q = 0; rr_q = 0;
    end else begin
      aw_hs = awv_q && awr_q;
      w_hs  = wv_q  && wr_q;
      b_hs  = bv_q  && br_q;
      ar_hs = arv_q && arr_q;
      r_hs  = rv_q  && rr_q;
      // a pending valid must stay up with stable payload
      if (awv_q && !awr_q) check("aw_hold", {axil.awvalid, axil.awaddr}, {1'b1, awaddr_q});
      if (wv_q  && !wr_q)  check("w_hold",  {axil.wvalid,  axil.wdata},  {1'b1, wdata_q});
      if (arv_q && !arr_q) check("ar_hold", {axil.arvalid, axil.araddr}, {1'b1, araddr_q});
      // once handshaken, AW/W stay quiet for the rest of that write
      if (aw_seen) check("aw_no_reassert", axil.awvalid, 1'b0);
      if (w_seen)  check("w_no_reassert",  axil.wvalid,  1'b0);

      if (aw_hs) begin
        axil.awready = 1'b0; got_aw = 1; aw_seen = 1; aw_addr_c = awaddr_q; aw_cnt = next_dly();
      end else if (axil.awvalid && !axil.awready) begin
        if (aw_cnt == 0) axil.awready = 1'b1; else aw_cnt--;
      end

      if (w_hs) begin
        axil.wready = 1'b0; got_w = 1; w_seen = 1; w_data_c = wdata_q; w_cnt = next_dly();
      end else if (axil.wvalid && !axil.wready) begin
        if (w_cnt == 0) axil.wready = 1'b1; else w_cnt--;
      end

      if (b_hs) begin
        axil.bvalid = 1'b0; aw_seen = 0; w_seen = 0; b_cnt = next_dly();
      end else if (!axil.bvalid && got_aw && got_w) begin
        if (b_cnt == 0) begin
          axil.bresp = resp_of(aw_addr_c);
          if (axil.bresp == 2'b00) slv_mem[aw_addr_c] = w_data_c;
          axil.bvalid = 1'b1; got_aw = 0; got_w = 0;
        end else b_cnt--;
      end

      if (ar_hs) begin
        axil.arready = 1'b0; got_ar = 1; ar_addr_c = araddr_q; ar_cnt = next_dly();
      end else if (axil.arvalid && !axil.arready) begin
        if (ar_cnt == 0) axil.arready = 1'b1; else ar_cnt--;
      end

      if (r_hs) begin
        axil.rvalid = 1'b0; r_cnt = next_dly();
      end else if (!axil.rvalid && got_ar) begin
        if (r_cnt == 0) begin
          axil.rdata = slv_rd(ar_addr_c); axil.rresp = resp_of(ar_addr_c);
          axil.rvalid = 1'b1; got_ar = 0;
        end else r_cnt--;
      end

      awv_q = axil.awvalid; awr_q = axil.awready; awaddr_q = axil.awaddr;
      wv_q  = axil.wvalid;  wr_q  = axil.wready;  wdata_q  = axil.wdata;
      bv_q  = axil.bvalid;  br_q  = axil.bready;
      arv_q = axil.arvalid; arr_q = axil.arready; araddr_q = axil.araddr;
      rv_q  = axil.rvalid;  rr_q  = axil.rready;
    end
  end

  // ---------------- reference model ----------------------------------------
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  function automatic logic exp_ok(input logic [AW-1:0] a);
    return a[7:6] != 2'b11;
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // ---------------- command driver -----------------------------------------
  // Waits (bounded) for rsp_valid, holds rsp_ready low rsp_wait cycles, then
  // consumes the response. n counts cycles spent waiting.
  task automatic wait_rsp(input int rsp_wait, output logic [DW-1:0] rd, output logic ok,
                          output int lat, output int vlat);
    int n = 0;
    rd = '0; ok = 1'b0; lat = -1; vlat = -1;
    while (!rsp_valid && n < 300) begin
      @(negedge clk); n++;
      // commands offered while busy must be ignored
      cmd_valid = 1'($urandom_range(0, 1)); cmd_we = 1'($urandom_range(0, 1));
      cmd_addr  = AW'($urandom); cmd_wdata = DW'($urandom);
      if (vlat < 0 && (axil.awvalid || axil.wvalid || axil.arvalid)) vlat = n;
    end
    if (!rsp_valid) begin
      check("rsp_timeout", 1'b0, 1'b1); cmd_valid = 1'b0; return;
    end
    lat = n;
    repeat (rsp_wait) @(negedge clk);
    cmd_valid = 1'b0; rsp_ready = 1'b1; rd = rsp_rdata; ok = rsp_okay;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic run_cmd(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input int rsp_wait, output int lat, output int vlat);
    logic [DW-1:0] rd, exp_d;
    logic ok;
    int n = 0;
    lat = -1; vlat = -1;
    exp_d = we ? '0 : ref_rd(addr);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wd;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      check("cmd_accept_timeout", 1'b0, 1'b1); cmd_valid = 1'b0; return;
    end
    wait_rsp(rsp_wait, rd, ok, lat, vlat);
    check(we ? "wr_rdata" : "rd_data", rd, exp_d);
    check(we ? "wr_okay" : "rd_okay", ok, exp_ok(addr));
    if (we && exp_ok(addr)) ref_mem[addr] = wd;
  endtask

  // ---------------- stimulus -----------------------------------------------
  int lat, vlat;
  logic [DW-1:0] rd_tmp;
  logic ok_tmp;

  initial begin
    slv_mem[32'h10] = 32'hDEAD_BEEF; ref_mem[32'h10] = 32'hDEAD_BEEF;
    slv_mem[32'hE0] = 32'hCAFE_F00D; ref_mem[32'hE0] = 32'hCAFE_F00D;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_valids", {axil.awvalid, axil.wvalid, axil.arvalid}, 3'b000);
    check("rst_readies", {axil.bready, axil.rready}, 2'b00);
    check("rst_rsp_data", {rsp_rdata, rsp_okay}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // zero-wait read: AR valid one cycle after accept, response three cycles after
    run_cmd(1'b0, 32'h10, '0, 0, lat, vlat);
    check("rd_valid_latency", 64'(vlat), 64'd1);
    check("rd_rsp_latency", 64'(lat), 64'd3);
    check("cmd_ready_after_rsp", cmd_ready, 1'b1);

    // zero-wait write latency
    run_cmd(1'b1, 32'h08, 32'hA5A5_0001, 0, lat, vlat);
    check("wr_rsp_latency", 64'(lat), 64'd3);

    // W accepted three cycles ahead of AW
    aw_cnt = 3;
    fork
      run_cmd(1'b1, 32'h04, 32'h1234_5678, 0, lat, vlat);
      begin
        repeat (3) @(negedge clk);
        check("w_dropped", {axil.wvalid, axil.awvalid}, 2'b01);
        @(negedge clk);
        check("bready_early", axil.bready, 1'b0);
        repeat (2) @(negedge clk);
        check("bready_after_both", axil.bready, 1'b1);
      end
    join

    // error responses
    run_cmd(1'b1, 32'hC0, 32'h1111_2222, 0, lat, vlat);  // SLVERR
    run_cmd(1'b0, 32'hE0, '0, 0, lat, vlat);              // DECERR, data passes
    run_cmd(1'b0, 32'hC0, '0, 0, lat, vlat);              // failed write left map alone

    // response backpressure with a new command waiting
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h10;
    @(negedge clk);
    cmd_we = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'h0BAD_F00D;
    for (int k = 0; k < 20 && !rsp_valid; k++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("bp_rsp", {rsp_valid, cmd_ready, rsp_rdata}, {1'b1, 1'b0, ref_rd(32'h10)});
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_idle_after_hs", {cmd_ready, rsp_valid}, 2'b10);
    @(negedge clk);
    check("bp_second_taken", {cmd_ready, axil.awvalid}, 2'b01);
    cmd_valid = 1'b0;
    wait_rsp(0, rd_tmp, ok_tmp, lat, vlat);
    check("bp_second_rsp", {rd_tmp, ok_tmp}, {32'h0, 1'b1});
    ref_mem[32'h20] = 32'h0BAD_F00D;

    // reset while waiting for R
    r_cnt = 6;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h30;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 20 && !axil.rready; k++) @(negedge clk);
    check("in_rd_r", axil.rready, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_outputs", {axil.awvalid, axil.wvalid, axil.arvalid, axil.bready, axil.rready,
                           rsp_valid, cmd_ready}, 7'b0000001);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("no_rsp_after_rst", {rsp_valid, cmd_ready}, 2'b01);
    end
    check("rsp_cleared_by_rst", {rsp_rdata, rsp_okay}, '0);

    // randomized mixed traffic with random slave delays
    max_dly = 7;
    for (int i = 0; i < 1000; i++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 63)) << 2;
      run_cmd(1'($urandom_range(0, 1)), a, DW'($urandom), int'($urandom_range(0, 3)), lat, vlat);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end
endmodule
